riscv_dmem_lsq: RTL



---
 rtl/biu_constants_pkg.sv | 11 +
 rtl/riscv_lsq_pkg.sv | 28 ++
 rtl/riscv_lsq_ldext.sv | 36 +++
 rtl/riscv_dmem_lsq.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/biu_constants_pkg.sv
// rtl/biu_constants_pkg.sv - bus interface size encodings shared with the biu
package biu_constants_pkg;

  typedef enum logic [2:0] {
    BYTE  = 3'b000,
    HWORD = 3'b001,
    WORD  = 3'b010,
    DWORD = 3'b011
  } biu_size_t;

endpackage

// File: rtl/riscv_lsq_pkg.sv
// rtl/riscv_lsq_pkg.sv - load/store queue entry types and RISC-V exception causes
package riscv_lsq_pkg;
  import biu_constants_pkg::*;

  typedef enum logic [1:0] {
    ST_FREE   = 2'd0,
    ST_QUEUED = 2'd1,
    ST_ISSUED = 2'd2
  } lsq_state_t;

  // Width-independent part of an entry; adr/d/pc live in XLEN-wide arrays in the top.
  typedef struct packed {
    logic       we;
    logic       sext;
    biu_size_t  size;
    logic [4:0] dst;
    lsq_state_t state;
    logic       killed;
  } lsq_ctrl_t;

  localparam logic [3:0] CAUSE_LD_MISALIGNED = 4'd4;
  localparam logic [3:0] CAUSE_LD_ACCESS     = 4'd5;
  localparam logic [3:0] CAUSE_ST_MISALIGNED = 4'd6;
  localparam logic [3:0] CAUSE_ST_ACCESS     = 4'd7;
  localparam logic [3:0] CAUSE_LD_PAGE       = 4'd13;
  localparam logic [3:0] CAUSE_ST_PAGE       = 4'd15;

endpackage

// File: rtl/riscv_lsq_ldext.sv
// rtl/riscv_lsq_ldext.sv - load lane select and sign/zero extension
module riscv_lsq_ldext
  import biu_constants_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int LB   = $clog2(XLEN/8)
) (
  input  logic [XLEN-1:0] i_q,
  input  logic [LB-1:0]   i_lane,
  input  biu_size_t       i_size,
  input  logic            i_sext,
  output logic [XLEN-1:0] o_r
);

  logic [XLEN-1:0] w_shift;
  logic            w_msb;
  int              w_bits;

  assign w_shift = i_q >> {i_lane, 3'b000};

  always_comb begin
    w_bits = XLEN;
    w_msb  = w_shift[XLEN-1];
    case (i_size)
      BYTE:    begin w_bits = 8;  w_msb = w_shift[7];  end
      HWORD:   begin w_bits = 16; w_msb = w_shift[15]; end
      WORD:    begin w_bits = 32; w_msb = w_shift[31]; end
      default: begin w_bits = XLEN; w_msb = w_shift[XLEN-1]; end
    endcase
    o_r = w_shift;
    for (int i = 0; i < XLEN; i++) begin
      if (i >= w_bits) o_r[i] = i_sext & w_msb;
    end
  end

endmodule

// File: rtl/riscv_dmem_lsq.sv
// rtl/riscv_dmem_lsq.sv - in-order load/store queue between the MEM stage and the dmem bus
module riscv_dmem_lsq
  import biu_constants_pkg::*;
  import riscv_lsq_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic                     req_we_i,
  input  logic                     req_sext_i,
  input  biu_size_t                req_size_i,
  input  logic [XLEN-1:0]          req_adr_i,
  input  logic [XLEN-1:0]          req_d_i,
  input  logic [4:0]               req_dst_i,
  input  logic [XLEN-1:0]          req_pc_i,
  input  logic                     flush_i,
  output logic                     dmem_req_o,
  output logic                     dmem_we_o,
  output biu_size_t                dmem_size_o,
  output logic [XLEN-1:0]          dmem_adr_o,
  output logic [XLEN-1:0]          dmem_d_o,
  input  logic [XLEN-1:0]          dmem_q_i,
  input  logic                     dmem_ack_i,
  input  logic                     dmem_err_i,
  input  logic                     dmem_misaligned_i,
  input  logic                     dmem_page_fault_i,
  output logic                     rsp_valid_o,
  output logic                     rsp_we_o,
  output logic [4:0]               rsp_dst_o,
  output logic [XLEN-1:0]          rsp_r_o,
  output logic                     rsp_exc_o,
  output logic [3:0]               rsp_cause_o,
  output logic [XLEN-1:0]          rsp_badaddr_o,
  output logic [XLEN-1:0]          rsp_pc_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     busy_o
);

  localparam int          AW   = $clog2(DEPTH);
  localparam int          LB   = $clog2(XLEN/8);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  lsq_ctrl_t       r_ctl [DEPTH];
  logic [XLEN-1:0] r_adr [DEPTH];
  logic [XLEN-1:0] r_d   [DEPTH];
  logic [XLEN-1:0] r_pc  [DEPTH];
  logic [AW-1:0]   r_alloc, r_issue, r_retire;
  logic [AW:0]     r_count;

  lsq_ctrl_t       w_iss, w_ret;
  logic            w_alloc, w_issue, w_cmpl, w_retire;
  logic            w_exc, w_rsp_ok, w_rsp_ld;
  logic [AW:0]     w_nqueued, w_count_nxt;
  logic [3:0]      w_cause;
  logic [XLEN-1:0] w_iss_d, w_st_d, w_ld_r;

  assign w_iss   = r_ctl[r_issue];
  assign w_ret   = r_ctl[r_retire];
  assign w_iss_d = r_d[r_issue];

  // Ready looks only at registered occupancy so dmem_ack_i never reaches req_ready_o.
  assign req_ready_o = (r_count != FULL);
  assign w_alloc     = req_valid_i & req_ready_o & ~flush_i;
  assign w_issue     = (w_iss.state == ST_QUEUED) & ~flush_i;
  assign w_cmpl      = dmem_ack_i | dmem_err_i | dmem_misaligned_i | dmem_page_fault_i;
  assign w_retire    = w_cmpl & (w_ret.state == ST_ISSUED);
  assign w_exc       = dmem_err_i | dmem_misaligned_i | dmem_page_fault_i;
  assign w_rsp_ok    = w_retire & ~w_ret.killed & ~flush_i;
  assign w_rsp_ld    = w_rsp_ok & ~w_ret.we & ~w_exc;

  always_comb begin
    w_nqueued = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_ctl[i].state == ST_QUEUED) w_nqueued = w_nqueued + 1'b1;
    end
  end

  assign w_count_nxt = r_count + {{AW{1'b0}}, w_alloc} - {{AW{1'b0}}, w_retire}
                     - (flush_i ? w_nqueued : '0);

  always_comb begin
    w_st_d = '0;
    for (int b = 0; b < XLEN/8; b++) begin
      case (w_iss.size)
        BYTE:    w_st_d[b*8 +: 8] = w_iss_d[7:0];
        HWORD:   w_st_d[b*8 +: 8] = w_iss_d[(b%2)*8 +: 8];
        WORD:    w_st_d[b*8 +: 8] = w_iss_d[(b%4)*8 +: 8];
        default: w_st_d[b*8 +: 8] = w_iss_d[b*8 +: 8];
      endcase
    end
  end

  assign dmem_req_o  = w_issue;
  assign dmem_we_o   = w_issue & w_iss.we;
  assign dmem_size_o = w_issue ? w_iss.size : BYTE;
  assign dmem_adr_o  = w_issue ? r_adr[r_issue] : '0;
  assign dmem_d_o    = w_issue ? w_st_d : '0;

  always_comb begin
    w_cause = 4'd0;
    if (dmem_misaligned_i)      w_cause = w_ret.we ? CAUSE_ST_MISALIGNED : CAUSE_LD_MISALIGNED;
    else if (dmem_page_fault_i) w_cause = w_ret.we ? CAUSE_ST_PAGE : CAUSE_LD_PAGE;
    else if (dmem_err_i)        w_cause = w_ret.we ? CAUSE_ST_ACCESS : CAUSE_LD_ACCESS;
  end

  riscv_lsq_ldext #(.XLEN(XLEN), .LB(LB)) u_ldext (
    .i_q    (dmem_q_i),
    .i_lane (r_adr[r_retire][LB-1:0]),
    .i_size (w_ret.size),
    .i_sext (w_ret.sext),
    .o_r    (w_ld_r)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) r_ctl[i] <= '0;
      r_alloc       <= '0;
      r_issue       <= '0;
      r_retire      <= '0;
      r_count       <= '0;
      rsp_valid_o   <= 1'b0;
      rsp_we_o      <= 1'b0;
      rsp_dst_o     <= '0;
      rsp_r_o       <= '0;
      rsp_exc_o     <= 1'b0;
      rsp_cause_o   <= '0;
      rsp_badaddr_o <= '0;
      rsp_pc_o      <= '0;
    end else begin
      r_count <= w_count_nxt;
      if (w_alloc) begin
        r_ctl[r_alloc] <= '{we: req_we_i, sext: req_sext_i, size: req_size_i,
                            dst: req_dst_i, state: ST_QUEUED, killed: 1'b0};
        r_adr[r_alloc] <= req_adr_i;
        r_d[r_alloc]   <= req_d_i;
        r_pc[r_alloc]  <= req_pc_i;
        r_alloc        <= r_alloc + 1'b1;
      end
      if (w_issue) begin
        r_ctl[r_issue].state <= ST_ISSUED;
        r_issue              <= r_issue + 1'b1;
      end
      if (w_retire) begin
        r_ctl[r_retire].state <= ST_FREE;
        r_retire              <= r_retire + 1'b1;
      end
      // Queued entries sit contiguously from issue to alloc, so rewinding alloc frees them.
      if (flush_i) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (r_ctl[i].state == ST_QUEUED) r_ctl[i].state  <= ST_FREE;
          if (r_ctl[i].state == ST_ISSUED) r_ctl[i].killed <= 1'b1;
        end
        r_alloc <= r_issue;
      end
      rsp_valid_o   <= w_rsp_ok;
      rsp_we_o      <= w_rsp_ld & (w_ret.dst != 5'd0);
      rsp_dst_o     <= w_rsp_ok ? w_ret.dst : 5'd0;
      rsp_r_o       <= w_rsp_ld ? w_ld_r : '0;
      rsp_exc_o     <= w_rsp_ok & w_exc;
      rsp_cause_o   <= (w_rsp_ok & w_exc) ? w_cause : 4'd0;
      rsp_badaddr_o <= (w_rsp_ok & w_exc) ? r_adr[r_retire] : '0;
      rsp_pc_o      <= w_rsp_ok ? r_pc[r_retire] : '0;
    end
  end

  assign count_o = r_count;
  assign busy_o  = (r_count != '0);

  a_cmpl_has_issued: assert property (@(posedge clk_i) disable iff (rst_i) w_cmpl |-> w_retire)
    else $warning("dmem completion with no issued entry ignored");

endmodule
